// File: rtl/iwrite_controller_top.sv
// iwrite_controller_top: ping-pong activation BRAM writer plus param register-file responder.
// Optional overflow flag enabled by defining IWRITE_OVERFLOW_CHK_EN.
`default_nettype none

module iwrite_controller_top #(
  parameter int WRITE_WIDTH = 64,
  parameter int WRITE_DEPTH = 512,
  parameter int PARAM_WIDTH = 32,
  parameter int PARAM_DEPTH = 16,
  localparam int AW = $clog2(WRITE_DEPTH),
  localparam int PW = $clog2(PARAM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef IWRITE_OVERFLOW_CHK_EN
  output logic                   err_overflow,
`endif
  input  logic [WRITE_WIDTH-1:0] s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   enaA,
  output logic                   weA,
  output logic [AW:0]            addrA_ping_pong,
  output logic [WRITE_WIDTH-1:0] diA,
  output logic [AW:0]            write_addr_pingpong_data,
  input  logic                   rd_bank_release,
  input  logic                   rd_bank_id,
  input  logic                   cfg_wr_valid,
  input  logic [PW-1:0]          cfg_wr_addr,
  input  logic [PARAM_WIDTH-1:0] cfg_wr_data,
  input  logic [PARAM_WIDTH-1:0] param_addr_rd,
  input  logic                   param_addr_valid_rd,
  output logic                   param_addr_ready_rd,
  output logic [PARAM_WIDTH-1:0] param_data_rd,
  output logic                   param_data_valid_rd,
  input  logic                   param_data_ready_rd
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WRITE_DEPTH - 1);

  typedef enum logic [0:0] {
    WRITE     = 1'b0,
    WAIT_BANK = 1'b1
  } state_t;

  state_t          state, state_next;
  logic            wr_bank, wr_bank_next;
  logic [AW-1:0]   wr_addr, wr_addr_next;
  logic [1:0]      bank_full, bank_full_next;
  logic            accept, addr_at_end, tile_end;

  assign addr_at_end = (wr_addr == LAST_ADDR);
  assign tile_end    = s_last | addr_at_end;
  assign s_ready     = (state == WRITE) & ~bank_full[wr_bank];
  assign accept      = s_valid & s_ready & ~rst;

  assign enaA            = accept;
  assign weA             = accept;
  assign addrA_ping_pong = accept ? {wr_addr, wr_bank} : '0;
  assign diA             = accept ? s_data : '0;

  always_comb begin
    bank_full_next = bank_full;
    wr_bank_next   = wr_bank;
    wr_addr_next   = wr_addr;
    state_next     = state;
    // Clear before set so a same-cycle tile-end on the released bank keeps it full.
    if (rd_bank_release) bank_full_next[rd_bank_id] = 1'b0;
    if (accept) begin
      if (tile_end) begin
        bank_full_next[wr_bank] = 1'b1;
        wr_bank_next            = ~wr_bank;
        wr_addr_next            = '0;
      end else begin
        wr_addr_next = wr_addr + 1'b1;
      end
    end
    case (state)
      WRITE:     if (accept && tile_end && bank_full_next[~wr_bank]) state_next = WAIT_BANK;
      WAIT_BANK: if (!bank_full_next[wr_bank]) state_next = WRITE;
      default:   state_next = WRITE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= WRITE;
      wr_bank                  <= 1'b0;
      wr_addr                  <= '0;
      bank_full                <= '0;
      write_addr_pingpong_data <= '0;
    end else begin
      state                    <= state_next;
      wr_bank                  <= wr_bank_next;
      wr_addr                  <= wr_addr_next;
      bank_full                <= bank_full_next;
      write_addr_pingpong_data <= {wr_bank_next, wr_addr_next};
    end
  end

`ifdef IWRITE_OVERFLOW_CHK_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      if (accept && addr_at_end && !s_last) err_overflow <= 1'b1;
      if (state == WAIT_BANK && s_valid) begin
        if (wait_cnt == 8'hFF) err_overflow <= 1'b1;
        else                   wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end
`endif

  // Param store is preloaded by config and intentionally survives reset.
  logic [PARAM_WIDTH-1:0] regfile [PARAM_DEPTH];
  logic [PW-1:0]          req_idx;
  logic                   req_fire;

  assign req_idx             = param_addr_rd[PW-1:0];
  assign param_addr_ready_rd = ~param_data_valid_rd;
  assign req_fire            = param_addr_valid_rd & param_addr_ready_rd;

  always_ff @(posedge clk) begin
    if (cfg_wr_valid) regfile[cfg_wr_addr] <= cfg_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      param_data_rd       <= '0;
      param_data_valid_rd <= 1'b0;
    end else if (req_fire) begin
      param_data_rd       <= (cfg_wr_valid && cfg_wr_addr == req_idx) ? cfg_wr_data : regfile[req_idx];
      param_data_valid_rd <= 1'b1;
    end else if (param_data_valid_rd && param_data_ready_rd) begin
      param_data_valid_rd <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iwrite_controller_top.sv
// Directed self-checking bench for iwrite_controller_top (default parameters).
`default_nettype none

module tb_iwrite_controller_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic        enaA, weA;
  logic [9:0]  addrA_ping_pong, write_addr_pingpong_data;
  logic [63:0] diA;
  logic        rd_bank_release, rd_bank_id;
  logic        cfg_wr_valid;
  logic [3:0]  cfg_wr_addr;
  logic [31:0] cfg_wr_data, param_addr_rd, param_data_rd;
  logic        param_addr_valid_rd, param_addr_ready_rd;
  logic        param_data_valid_rd, param_data_ready_rd;
`ifdef IWRITE_OVERFLOW_CHK_EN
  logic        err_overflow;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iwrite_controller_top dut (
    .clk(clk), .rst(rst),
`ifdef IWRITE_OVERFLOW_CHK_EN
    .err_overflow(err_overflow),
`endif
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .enaA(enaA), .weA(weA), .addrA_ping_pong(addrA_ping_pong), .diA(diA),
    .write_addr_pingpong_data(write_addr_pingpong_data),
    .rd_bank_release(rd_bank_release), .rd_bank_id(rd_bank_id),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .param_addr_rd(param_addr_rd), .param_addr_valid_rd(param_addr_valid_rd),
    .param_addr_ready_rd(param_addr_ready_rd), .param_data_rd(param_data_rd),
    .param_data_valid_rd(param_data_valid_rd), .param_data_ready_rd(param_data_ready_rd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_data = '0; s_valid = 0; s_last = 0;
    rd_bank_release = 0; rd_bank_id = 0;
    cfg_wr_valid = 0; cfg_wr_addr = '0; cfg_wr_data = '0;
    param_addr_rd = '0; param_addr_valid_rd = 0; param_data_ready_rd = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({s_ready, enaA, weA, addrA_ping_pong, diA, write_addr_pingpong_data} !== {3'b100, 10'd0, 64'd0, 10'd0}) begin
      errors++; $display("FAIL reset_stream: got rdy=%b en=%b we=%b a=%h ptr=%h expected rdy=1 others 0",
                         s_ready, enaA, weA, addrA_ping_pong, write_addr_pingpong_data);
    end
    checks++;
    if ({param_addr_ready_rd, param_data_valid_rd, param_data_rd} !== {2'b10, 32'd0}) begin
      errors++; $display("FAIL reset_param: got ardy=%b dv=%b d=%h expected 1 0 0",
                         param_addr_ready_rd, param_data_valid_rd, param_data_rd);
    end
`ifdef IWRITE_OVERFLOW_CHK_EN
    checks++;
    if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_overflow); end
`endif
  endtask

  task automatic test_basic_tile();
    logic [9:0] exp_ptr;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = 64'h11 + 64'(i); s_last = (i == 3);
      #1;
      checks++;
      if (enaA !== 1 || weA !== 1 || addrA_ping_pong !== 10'(i << 1) || diA !== 64'h11 + 64'(i)) begin
        errors++; $display("FAIL basic_write%0d: got en=%b we=%b a=%h d=%h expected 1 1 %h %h",
                           i, enaA, weA, addrA_ping_pong, diA, 10'(i << 1), 64'h11 + 64'(i));
      end
      step();
      exp_ptr = (i == 3) ? 10'h200 : 10'(i + 1);
      checks++;
      if (write_addr_pingpong_data !== exp_ptr) begin
        errors++; $display("FAIL basic_ptr%0d: got %h expected %h", i, write_addr_pingpong_data, exp_ptr);
      end
    end
    s_valid = 0; s_last = 0;
    #1;
    checks++;
    if (s_ready !== 1 || enaA !== 0) begin
      errors++; $display("FAIL basic_idle: got rdy=%b en=%b expected 1 0", s_ready, enaA);
    end
  endtask

  task automatic test_fill_wait_release();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = 64'hA0 + 64'(i); s_last = (i == 1 || i == 3);
      #1;
      if (i == 3) begin
        checks++;
        if (addrA_ping_pong !== 10'd3 || enaA !== 1) begin
          errors++; $display("FAIL fill_b1_last: got a=%h en=%b expected 003 1", addrA_ping_pong, enaA);
        end
      end
      step();
      if (i == 1) begin
        checks++;
        if (s_ready !== 1 || write_addr_pingpong_data !== 10'h200) begin
          errors++; $display("FAIL fill_b0_done: got rdy=%b ptr=%h expected 1 200", s_ready, write_addr_pingpong_data);
        end
      end
    end
    s_last = 0;
    checks++;
    if (s_ready !== 0 || enaA !== 0 || write_addr_pingpong_data !== 10'h000) begin
      errors++; $display("FAIL fill_wait: got rdy=%b en=%b ptr=%h expected 0 0 000", s_ready, enaA, write_addr_pingpong_data);
    end
    step();
    checks++;
    if (s_ready !== 0 || enaA !== 0) begin
      errors++; $display("FAIL fill_wait_hold: got rdy=%b en=%b expected 0 0", s_ready, enaA);
    end
    s_valid = 0; rd_bank_release = 1; rd_bank_id = 0;
    #1;
    checks++;
    if (s_ready !== 0) begin errors++; $display("FAIL release_same_cycle: got rdy=%b expected 0", s_ready); end
    step();
    rd_bank_release = 0;
    checks++;
    if (s_ready !== 1) begin errors++; $display("FAIL release_ready: got rdy=%b expected 1", s_ready); end
    s_valid = 1; s_data = 64'hC0;
    #1;
    checks++;
    if (enaA !== 1 || addrA_ping_pong !== 10'd0 || diA !== 64'hC0) begin
      errors++; $display("FAIL resume_write: got en=%b a=%h d=%h expected 1 000 c0", enaA, addrA_ping_pong, diA);
    end
    step();
    s_valid = 0;
  endtask

  task automatic test_forced_tile_end();
    do_reset();
    for (int i = 0; i < 512; i++) begin
      s_valid = 1; s_data = 64'(i); s_last = 0;
      #1;
      if (i == 511) begin
        checks++;
        if (enaA !== 1 || addrA_ping_pong !== 10'h3FE) begin
          errors++; $display("FAIL forced_last_addr: got en=%b a=%h expected 1 3fe", enaA, addrA_ping_pong);
        end
      end
      step();
      if (i == 510) begin
        checks++;
        if (write_addr_pingpong_data !== 10'h1FF) begin
          errors++; $display("FAIL forced_ptr510: got %h expected 1ff", write_addr_pingpong_data);
        end
      end
    end
    s_valid = 0;
    checks++;
    if (write_addr_pingpong_data !== 10'h200 || s_ready !== 1) begin
      errors++; $display("FAIL forced_toggle: got ptr=%h rdy=%b expected 200 1", write_addr_pingpong_data, s_ready);
    end
`ifdef IWRITE_OVERFLOW_CHK_EN
    checks++;
    if (err_overflow !== 1) begin errors++; $display("FAIL forced_err: got %b expected 1", err_overflow); end
`endif
    s_valid = 1; s_data = 64'h55;
    #1;
    checks++;
    if (addrA_ping_pong !== 10'd1 || enaA !== 1) begin
      errors++; $display("FAIL forced_next_bank: got a=%h en=%b expected 001 1", addrA_ping_pong, enaA);
    end
    step();
    s_valid = 0;
  endtask

  task automatic test_param_backpressure();
    do_reset();
    cfg_wr_valid = 1; cfg_wr_addr = 4'd3; cfg_wr_data = 32'hDEADBEEF;
    step();
    cfg_wr_valid = 0;
    param_addr_rd = 32'd3; param_addr_valid_rd = 1; param_data_ready_rd = 0;
    #1;
    checks++;
    if (param_addr_ready_rd !== 1 || param_data_valid_rd !== 0) begin
      errors++; $display("FAIL param_req: got ardy=%b dv=%b expected 1 0", param_addr_ready_rd, param_data_valid_rd);
    end
    step();
    param_addr_valid_rd = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (param_data_valid_rd !== 1 || param_data_rd !== 32'hDEADBEEF || param_addr_ready_rd !== 0) begin
        errors++; $display("FAIL param_hold%0d: got dv=%b d=%h ardy=%b expected 1 deadbeef 0",
                           c, param_data_valid_rd, param_data_rd, param_addr_ready_rd);
      end
      if (c < 2) step();
    end
    param_data_ready_rd = 1;
    step();
    param_data_ready_rd = 0;
    checks++;
    if (param_data_valid_rd !== 0 || param_addr_ready_rd !== 1) begin
      errors++; $display("FAIL param_release: got dv=%b ardy=%b expected 0 1", param_data_valid_rd, param_addr_ready_rd);
    end
  endtask

  task automatic test_param_collision();
    do_reset();
    cfg_wr_valid = 1; cfg_wr_addr = 4'd5; cfg_wr_data = 32'h1234;
    step();
    cfg_wr_data = 32'hA5;
    param_addr_rd = 32'h25; param_addr_valid_rd = 1; param_data_ready_rd = 1;
    step();
    cfg_wr_valid = 0; param_addr_valid_rd = 0;
    checks++;
    if (param_data_valid_rd !== 1 || param_data_rd !== 32'hA5) begin
      errors++; $display("FAIL param_collision: got dv=%b d=%h expected 1 000000a5", param_data_valid_rd, param_data_rd);
    end
    step();
    param_data_ready_rd = 0;
  endtask

  task automatic test_reset_midtile();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      s_valid = 1; s_data = 64'hE0 + 64'(i); s_last = 0;
      step();
    end
    s_valid = 0;
    cfg_wr_valid = 1; cfg_wr_addr = 4'd7; cfg_wr_data = 32'h77;
    param_addr_rd = 32'd7; param_addr_valid_rd = 1;
    step();
    cfg_wr_valid = 0; param_addr_valid_rd = 0;
    rst = 1;
    step();
    rst = 0;
    checks++;
    if ({s_ready, enaA, write_addr_pingpong_data, param_addr_ready_rd, param_data_valid_rd, param_data_rd}
        !== {2'b10, 10'd0, 2'b10, 32'd0}) begin
      errors++; $display("FAIL midtile_reset: got rdy=%b en=%b ptr=%h ardy=%b dv=%b d=%h expected 1 0 000 1 0 0",
                         s_ready, enaA, write_addr_pingpong_data, param_addr_ready_rd, param_data_valid_rd, param_data_rd);
    end
    s_valid = 1; s_data = 64'hF0;
    #1;
    checks++;
    if (enaA !== 1 || addrA_ping_pong !== 10'd0) begin
      errors++; $display("FAIL midtile_next: got en=%b a=%h expected 1 000", enaA, addrA_ping_pong);
    end
    step();
    s_valid = 0;
    checks++;
    if (write_addr_pingpong_data !== 10'd1) begin
      errors++; $display("FAIL midtile_ptr: got %h expected 001", write_addr_pingpong_data);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_basic_tile();
    test_fill_wait_release();
    test_forced_tile_end();
    test_param_backpressure();
    test_param_collision();
    test_reset_midtile();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iwrite_controller_top.md
Name: iwrite_controller_top

Overview:
- Write-side controller for the input-activation BRAM (ping-pong) and for the layer parameter store.
- Accepts an activation stream and writes it through BRAM port A into alternating banks. Publishes the live write pointer `{bank, addr}` to the read controller, which uses it for its empty test.
- Acts as responder on the param address/data channels issued by the read controller. Params are preloaded over a dedicated config write channel.

Parameters:
- WRITE_WIDTH, 64, BRAM port A data width and stream word width.
- WRITE_DEPTH, 512, words per bank (power of 2); AW = $clog2(WRITE_DEPTH).
- PARAM_WIDTH, 32, param word width and param address width.
- PARAM_DEPTH, 16, param register-file entries (power of 2); PW = $clog2(PARAM_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_data  in  WRITE_WIDTH  activation stream word
- s_valid  in  1  stream valid
- s_last  in  1  last word of tile
- s_ready  out  1  stream ready
- enaA  out  1  BRAM port A enable
- weA  out  1  BRAM port A write enable
- addrA_ping_pong  out  AW+1  `{wr_addr, wr_bank}` (bank is LSB)
- diA  out  WRITE_WIDTH  BRAM write data
- write_addr_pingpong_data  out  AW+1  `{wr_bank, wr_addr}` write pointer (bank is MSB)
- rd_bank_release  in  1  one-cycle pulse: reader finished bank rd_bank_id
- rd_bank_id  in  1  bank being released
- cfg_wr_valid  in  1  param preload valid
- cfg_wr_addr  in  PW  param preload index
- cfg_wr_data  in  PARAM_WIDTH  param preload data
- param_addr_rd  in  PARAM_WIDTH  param request address
- param_addr_valid_rd  in  1  request valid
- param_addr_ready_rd  out  1  request ready
- param_data_rd  out  PARAM_WIDTH  param response data
- param_data_valid_rd  out  1  response valid
- param_data_ready_rd  in  1  response ready

Behaviour:
- Reset values. Every output is 0, except:
  - s_ready = 1.
  - param_addr_ready_rd = 1.
- Reset contents:
  - wr_bank = 0, wr_addr = 0.
  - bank_full[1:0] = 0.
  - Param register file is not cleared.
- Reset asserted mid-tile abandons the partial tile; both banks are treated empty.
- FSM states:
  - WRITE: s_ready = !bank_full[wr_bank].
  - WAIT_BANK: s_ready = 0.
- Write path (combinational to BRAM in the accept cycle):
  - A stream word is accepted when s_valid & s_ready.
  - On accept: enaA = weA = 1, addrA_ping_pong = `{wr_addr, wr_bank}`, diA = s_data.
  - weA is only ever 1 together with enaA.
- Write pointer update, on the clock edge of an accept:
  - If the word is not tile-end: wr_addr increments.
  - A word is tile-end if s_last = 1 or wr_addr == WRITE_DEPTH-1.
  - On tile-end: bank_full[wr_bank] is set, wr_bank toggles, wr_addr = 0.
  - If the new bank is already full, go to WAIT_BANK; otherwise stay in WRITE.
- write_addr_pingpong_data:
  - Registered copy of `{wr_bank, wr_addr}` after the update.
  - Visible the cycle after the BRAM write edge, so the data is always in BRAM before the pointer advertises it.
- Bank release:
  - rd_bank_release clears bank_full[rd_bank_id].
  - In WAIT_BANK, once bank_full[wr_bank] is cleared, go to WRITE; s_ready rises the cycle after the release.
  - Release of a bank that is already empty is ignored.
  - Release in the same cycle as a tile-end set on the same bank: the set wins.
- Param preload:
  - cfg_wr_valid writes regfile[cfg_wr_addr] at the clock edge.
  - Preload has priority over a same-cycle read of the same index; the read returns the new value.
- Param responder (single outstanding request):
  - param_addr_ready_rd = !param_data_valid_rd.
  - On a request handshake: param_data_rd <= regfile[param_addr_rd[PW-1:0]] and param_data_valid_rd <= 1, both the next cycle. Latency is 1.
  - Upper address bits are ignored.
  - param_data_valid_rd holds, with data stable, until param_data_ready_rd; it clears on that edge.
  - A new request is accepted only from the following cycle.
- Stream and param paths are independent and may be active in the same cycle.

Optional Feature:
- Macro: IWRITE_OVERFLOW_CHK_EN.
- Defined:
  - Adds output err_overflow (1 bit, reset 0).
  - err_overflow sets and stays set until rst when a tile-end is forced by wr_addr == WRITE_DEPTH-1 with s_last = 0.
  - Also sets when s_valid is high while in WAIT_BANK for more than 255 consecutive cycles.
- Not defined: port absent; the forced tile-end still occurs silently.

Test Plan:
- Reset, then 4 words 0x11..0x14 with s_last on the 4th:
  - BRAM writes at addrA_ping_pong = `{0,0}`..`{3,0}`.
  - Pointer reads 0x001..0x003, then `{1, 0}`.
  - bank_full = 2'b01.
- Fill bank 0, then bank 1, with no release:
  - s_ready drops the cycle after bank 1's s_last; FSM in WAIT_BANK.
  - Pulse rd_bank_release with rd_bank_id = 0: s_ready returns next cycle and writes resume at bank 0, addr 0.
- Tile of WRITE_DEPTH words with s_last = 0:
  - Forced tile-end after word 511; bank toggles.
  - err_overflow = 1 when IWRITE_OVERFLOW_CHK_EN is defined.
- Preload regfile[3] = 0xDEADBEEF, then request param_addr_rd = 3 with param_data_ready_rd held 0 for 3 cycles:
  - param_data_valid_rd high from cycle +1, data stable, param_addr_ready_rd = 0.
  - Valid clears on the ready handshake.
- Same-cycle cfg_wr_valid to index 5 = 0xA5 and request for address 0x25: response data = 0xA5.
- Assert rst mid-tile after 2 words:
  - All outputs return to reset values; the next word is written at `{0,0}`.
